asic_iopad_seq: RTL and testbench

//  Power-up/hold/power-down sequencer and static config register bank for NPADS sky130 gpiov2 pads.

---
 rtl/asic_iopad_seq.sv | 123 ++++++++++++
 tb/tb_asic_iopad_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/asic_iopad_seq.sv
// asic_iopad_seq: power-up / hold / power-down sequencer and per-pad static
// configuration bank for sky130 gpiov2 pads. Drives every pad's 16-bit
// tech_cfg word so supplies, ENABLE_H and HLD_H_N come up and go down in the
// order the pad cell needs. All outputs come straight from registers.
module asic_iopad_seq #(
  parameter int NPADS = 8,
  parameter int TWAIT = 16,
  parameter int CW    = 16,
  localparam int AW   = (NPADS > 1) ? $clog2(NPADS) : 1,
  localparam int CNTW = (TWAIT > 1) ? $clog2(TWAIT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold_req,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [7:0]            cfg_wdata,
  output logic                  cfg_err,
  output logic                  ready,
  output logic [2:0]            state,
  output logic [NPADS*CW-1:0]   tech_cfg
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_PWR  = 3'd1,
    S_ENA  = 3'd2,
    S_REL  = 3'd3,
    S_RUN  = 3'd4,
    S_HOLD = 3'd5,
    S_DIS  = 3'd6,
    S_PDN  = 3'd7
  } state_t;

  // {ANALOG_EN, HLD_OVR, DM[2:0], SLOW, VTRIP_SEL, IB_MODE_SEL}; DM=110 at reset
  localparam logic [7:0] CFG_RST = 8'h30;

  state_t            r_state;
  state_t            w_next;
  logic [CNTW-1:0]   r_cnt;
  logic              r_sup;
  logic              r_en;
  logic              r_hld;
  logic              r_ready;
  logic              r_err;
  logic [7:0]        r_cfg [NPADS];
  logic              w_done;
  logic              w_wr_ok;
  logic [NPADS*CW-1:0] w_tech;

  assign w_done  = (r_cnt == '0);
  // Electrical options may only change while pads are off or frozen
  assign w_wr_ok = ((r_state == S_OFF) || (r_state == S_HOLD)) &&
                   (32'(cfg_addr) < NPADS);

  // Next-state decode; start=0 always wins over hold_req
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OFF:  if (start) w_next = S_PWR;
      S_PWR:  if (!start) w_next = S_PDN; else if (w_done) w_next = S_ENA;
      S_ENA:  if (!start) w_next = S_DIS; else if (w_done) w_next = S_REL;
      S_REL:  if (!start) w_next = S_DIS; else if (w_done) w_next = S_RUN;
      S_RUN:  if (!start) w_next = S_DIS; else if (hold_req) w_next = S_HOLD;
      S_HOLD: if (!start) w_next = S_DIS;
              else if (!hold_req && w_done) w_next = S_REL;
      S_DIS:  if (w_done) w_next = S_PDN;
      S_PDN:  if (w_done) w_next = S_OFF;
      default: w_next = S_OFF;
    endcase
  end

  // State, step timer and pad control bits, all updated on the entry edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_OFF;
      r_cnt   <= CNTW'(TWAIT - 1);
      r_sup   <= 1'b0;
      r_en    <= 1'b0;
      r_hld   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= CNTW'(TWAIT - 1);
      else if (!w_done)
        r_cnt <= r_cnt - 1'b1;
      r_sup   <= (w_next != S_OFF);
      r_en    <= (w_next == S_ENA) || (w_next == S_REL) || (w_next == S_RUN) ||
                 (w_next == S_HOLD) || (w_next == S_DIS);
      r_hld   <= (w_next == S_REL) || (w_next == S_RUN);
      r_ready <= (w_next == S_RUN);
    end
  end

  // Config bank writes and the one-cycle reject pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
      for (int i = 0; i < NPADS; i++) r_cfg[i] <= CFG_RST;
    end else begin
      r_err <= cfg_we && !w_wr_ok;
      if (cfg_we && w_wr_ok) r_cfg[cfg_addr] <= cfg_wdata;
    end
  end

  // Per-pad word assembly: registered config bits plus the shared control bits
  always_comb begin
    w_tech = '0;
    for (int i = 0; i < NPADS; i++) begin
      w_tech[i*CW +: 16] = {r_cfg[i][5:3], 2'b00, r_cfg[i][7], r_cfg[i][6],
                            r_cfg[i][2], r_cfg[i][1], r_cfg[i][0],
                            {3{r_sup}}, 1'b0, r_en, r_hld};
    end
  end

  assign tech_cfg = w_tech;
  assign ready    = r_ready;
  assign cfg_err  = r_err;
  assign state    = r_state;

endmodule

// File: tb/tb_asic_iopad_seq.sv
// tb_asic_iopad_seq: directed table of per-row inputs with hand-computed
// state/ready/cfg_err and pad 0 / pad 3 words, plus latency sequences and a
// per-cycle check of the pad enable ordering invariant.
module tb_asic_iopad_seq;
  localparam int NPADS = 6;
  localparam int TWAIT = 4;
  localparam int CW    = 16;
  localparam int AW    = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                hold_req = 1'b0;
  logic                cfg_we = 1'b0;
  logic [AW-1:0]       cfg_addr = '0;
  logic [7:0]          cfg_wdata = '0;
  logic                cfg_err;
  logic                ready;
  logic [2:0]          state;
  logic [NPADS*CW-1:0] tech_cfg;

  int n_vec  = 0;
  int n_miss = 0;

  asic_iopad_seq #(.NPADS(NPADS), .TWAIT(TWAIT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold_req(hold_req),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .ready(ready), .state(state), .tech_cfg(tech_cfg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, hold, we;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    int          rep;
    logic [2:0]  st;
    logic        rdy, err;
    logic [15:0] p0, p3;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, s, h, w, input logic [2:0] a,
                     input logic [7:0] d, input int rep, input logic [2:0] st,
                     input logic rdy, err, input logic [15:0] p0, p3);
    vec_t v;
    v.rst = r; v.start = s; v.hold = h; v.we = w; v.addr = a; v.wdata = d;
    v.rep = rep; v.st = st; v.rdy = rdy; v.err = err; v.p0 = p0; v.p3 = p3;
    vq.push_back(v);
  endtask

  // Ordering invariant and constant-zero bits, every cycle
  always @(negedge clk) begin
    for (int i = 0; i < NPADS; i++) begin
      logic [15:0] w;
      w = tech_cfg[i*CW +: 16];
      if ((w[0] && !w[1]) || (w[1] && w[5:3] != 3'b111) || w[2] || w[12:11] != 2'b00) begin
        $display("FAIL invariant pad%0d t=%0t: word=%h", i, $time, w);
        n_miss++;
      end
    end
  end

  initial begin
    int cyc;
    // rst st ho we addr wdata rep  state rdy err  p0       p3
    add(1,0,0,0,0,8'h00,1, 3'd0,0,0, 16'hC000,16'hC000);
    add(0,0,0,0,0,8'h00,2, 3'd0,0,0, 16'hC000,16'hC000);
    add(0,1,0,0,0,8'h00,1, 3'd1,0,0, 16'hC038,16'hC038); // PWR@1
    add(0,1,0,0,0,8'h00,3, 3'd1,0,0, 16'hC038,16'hC038);
    add(0,1,0,0,0,8'h00,1, 3'd2,0,0, 16'hC03A,16'hC03A); // ENA@5
    add(0,1,0,0,0,8'h00,3, 3'd2,0,0, 16'hC03A,16'hC03A);
    add(0,1,0,0,0,8'h00,1, 3'd3,0,0, 16'hC03B,16'hC03B); // REL@9
    add(0,1,0,0,0,8'h00,3, 3'd3,0,0, 16'hC03B,16'hC03B);
    add(0,1,0,0,0,8'h00,1, 3'd4,1,0, 16'hC03B,16'hC03B); // RUN@13
    add(0,1,0,1,3,8'h10,1, 3'd4,1,1, 16'hC03B,16'hC03B); // write in RUN rejected
    add(0,1,0,0,0,8'h00,1, 3'd4,1,0, 16'hC03B,16'hC03B);
    add(0,1,1,0,0,8'h00,1, 3'd5,0,0, 16'hC03A,16'hC03A); // HOLD
    add(0,1,1,1,3,8'h10,1, 3'd5,0,0, 16'hC03A,16'h403A); // write in HOLD
    add(0,1,1,1,6,8'hFF,1, 3'd5,0,1, 16'hC03A,16'h403A); // addr=NPADS
    add(0,1,1,1,7,8'hFF,1, 3'd5,0,1, 16'hC03A,16'h403A);
    add(0,1,1,0,0,8'h00,2, 3'd5,0,0, 16'hC03A,16'h403A); // timer parked at 0
    add(0,1,0,0,0,8'h00,1, 3'd3,0,0, 16'hC03B,16'h403B); // release -> REL
    add(0,1,0,0,0,8'h00,3, 3'd3,0,0, 16'hC03B,16'h403B);
    add(0,1,0,0,0,8'h00,1, 3'd4,1,0, 16'hC03B,16'h403B);
    add(0,0,1,0,0,8'h00,1, 3'd6,0,0, 16'hC03A,16'h403A); // stop beats hold
    add(0,0,0,0,0,8'h00,3, 3'd6,0,0, 16'hC03A,16'h403A);
    add(0,0,0,0,0,8'h00,1, 3'd7,0,0, 16'hC038,16'h4038);
    add(0,0,0,0,0,8'h00,2, 3'd7,0,0, 16'hC038,16'h4038);
    add(1,0,0,0,0,8'h00,1, 3'd0,0,0, 16'hC000,16'hC000); // rst mid-PDN
    add(0,0,0,1,0,8'hC7,1, 3'd0,0,0, 16'h07C0,16'hC000); // write in OFF
    add(0,1,0,1,3,8'h08,1, 3'd1,0,0, 16'h07F8,16'h2038); // write on OFF exit
    add(0,1,0,0,0,8'h00,3, 3'd1,0,0, 16'h07F8,16'h2038);
    add(0,1,0,0,0,8'h00,1, 3'd2,0,0, 16'h07FA,16'h203A);
    add(0,0,0,0,0,8'h00,1, 3'd6,0,0, 16'h07FA,16'h203A); // stop during ENA
    add(0,0,0,0,0,8'h00,3, 3'd6,0,0, 16'h07FA,16'h203A);
    add(0,0,0,0,0,8'h00,1, 3'd7,0,0, 16'h07F8,16'h2038);
    add(0,0,0,0,0,8'h00,3, 3'd7,0,0, 16'h07F8,16'h2038);
    add(0,0,0,0,0,8'h00,1, 3'd0,0,0, 16'h07C0,16'h2000);
    add(0,1,0,0,0,8'h00,1, 3'd1,0,0, 16'h07F8,16'h2038);
    add(0,0,0,0,0,8'h00,1, 3'd7,0,0, 16'h07F8,16'h2038); // stop during PWR
    add(0,0,0,1,0,8'h00,3, 3'd7,0,1, 16'h07F8,16'h2038); // write in PDN rejected
    add(0,0,0,0,0,8'h00,1, 3'd0,0,0, 16'h07C0,16'h2000);

    @(posedge clk); #1;
    foreach (vq[k]) begin
      rst = vq[k].rst; start = vq[k].start; hold_req = vq[k].hold;
      cfg_we = vq[k].we; cfg_addr = vq[k].addr; cfg_wdata = vq[k].wdata;
      repeat (vq[k].rep) @(posedge clk);
      #1;
      n_vec++;
      if (state !== vq[k].st || ready !== vq[k].rdy || cfg_err !== vq[k].err ||
          tech_cfg[0 +: 16] !== vq[k].p0 || tech_cfg[3*CW +: 16] !== vq[k].p3) begin
        $display("FAIL vec%0d: got st=%0d rdy=%b err=%b p0=%h p3=%h want st=%0d rdy=%b err=%b p0=%h p3=%h",
                 k, state, ready, cfg_err, tech_cfg[0 +: 16], tech_cfg[3*CW +: 16],
                 vq[k].st, vq[k].rdy, vq[k].err, vq[k].p0, vq[k].p3);
        n_miss++;
      end
    end
    cfg_we = 0; hold_req = 0;

    // Bring-up latency: start sampled to ready
    rst = 1; start = 0;
    @(posedge clk); #1;
    rst = 0; start = 1;
    cyc = 0;
    while (!ready && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (cyc != 3*TWAIT+1) begin
      $display("FAIL bringup_latency: got %0d cycles want %0d", cyc, 3*TWAIT+1);
      n_miss++;
    end

    // Power-down latency: DIS entry to OFF
    start = 0;
    cyc = 0;
    while (state != 3'd6 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (state != 3'd6 || ready !== 1'b0) begin
      $display("FAIL dis_entry: got st=%0d rdy=%b want st=6 rdy=0", state, ready);
      n_miss++;
    end
    cyc = 0;
    while (state != 3'd0 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (cyc != 2*TWAIT) begin
      $display("FAIL powerdown_latency: got %0d cycles want %0d", cyc, 2*TWAIT);
      n_miss++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
